rom_boot_loader: RTL and testbench

Synthesizable boot loader that sits directly upstream of cpu_top. It receives a framed program image over a byte-stream valid/ready interface and writes it, as 32-bit words, into the instruction ROM write port. The CPU core is held in reset until the image has loaded and its checksum has been verified. This replaces simulation-only `$readmemb` preloading, so self-test images can be loaded on silicon and FPGA.

---
 rtl/rom_boot_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_rom_boot_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_boot_loader
//  Description : Receives a framed program image over a byte stream
//                (MAGIC, len lo, len hi, len x 4-byte LE words, XOR checksum),
//                writes it word by word into the instruction ROM write port,
//                and releases the CPU reset once the checksum has matched.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_boot_loader #(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [7:0]  MAGIC   = 8'hA5,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              cpu_rest_o,
    output logic              boot_done_o,
    output logic              boot_err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned ROM_WORDS = 32'd1 << ADDR_W;
    // Counter wide enough to hold TIMEOUT itself; never narrower than 1 bit.
    localparam int unsigned TMO_W     = $clog2(TIMEOUT + 2);
    // The counter value that, with no byte this cycle, means "TIMEOUT reached".
    localparam int unsigned TMO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_next_state;

    logic [15:0]       r_len;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W:0]   r_waddr;      // one extra bit so len == ROM_WORDS fits
    logic [23:0]       r_word;       // lanes 0..2; lane 3 arrives with the write
    logic [7:0]        r_csum;
    logic [TMO_W-1:0]  r_tmo_cnt;

    logic              w_accept;
    logic [15:0]       w_len_full;
    logic              w_len_too_big;
    logic              w_last_word;
    logic              w_word_done;
    logic              w_in_frame;
    logic              w_timeout;

    logic              w_ready_nxt;
    logic              w_cpu_rest_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    assign w_accept      = rx_valid_i & rx_ready_o;
    assign w_len_full    = {rx_data_i, r_len[7:0]};
    assign w_len_too_big = (32'(w_len_full) > ROM_WORDS);
    assign w_last_word   = ((32'(r_waddr) + 32'd1) == 32'(r_len));
    assign w_word_done   = w_accept && (r_state == S_DATA) && (r_byte_idx == 2'd3);
    assign w_in_frame    = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                           (r_state == S_DATA) || (r_state == S_CSUM);
    // An accepted byte on the critical cycle always beats the timeout.
    assign w_timeout     = (TIMEOUT != 0) && w_in_frame && !w_accept &&
                           (r_tmo_cnt == TMO_W'(TMO_LAST));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: only accepted bytes and the timeout move the FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (rx_data_i == MAGIC)) begin
                    w_next_state = S_LEN0;
                end
            end
            S_LEN0: begin
                if (w_accept) begin
                    w_next_state = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (w_len_too_big) begin
                        w_next_state = S_ERR;
                    end else if (w_len_full == 16'd0) begin
                        w_next_state = S_CSUM;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_done && w_last_word) begin
                    w_next_state = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_next_state = (rx_data_i == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  w_next_state = S_DONE;
            S_ERR:   w_next_state = S_ERR;
            default: w_next_state = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = S_ERR;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered status outputs, decoded
    // from the next state so they change on the edge that enters DONE/ERR
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready_nxt    = (w_next_state != S_DONE) && (w_next_state != S_ERR);
        w_cpu_rest_nxt = (w_next_state == S_DONE);
        w_done_nxt     = (w_next_state == S_DONE);
        w_err_nxt      = (w_next_state == S_ERR);
    end

    // ------------------------------------------------------------------------
    // Registered outputs and ROM write stage (single pipeline register)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rx_ready_o  <= 1'b0;
            rom_we_o    <= 1'b0;
            rom_waddr_o <= '0;
            rom_wdata_o <= 32'd0;
            cpu_rest_o  <= 1'b0;
            boot_done_o <= 1'b0;
            boot_err_o  <= 1'b0;
        end else begin
            rx_ready_o  <= w_ready_nxt;
            cpu_rest_o  <= w_cpu_rest_nxt;
            boot_done_o <= w_done_nxt;
            boot_err_o  <= w_err_nxt;
            rom_we_o    <= w_word_done;
            if (w_word_done) begin
                rom_waddr_o <= r_waddr[ADDR_W-1:0];
                rom_wdata_o <= {rx_data_i, r_word};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Inter-byte timeout counter, active only inside a frame
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_tmo_cnt <= '0;
        end else if (w_in_frame && !w_accept) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Frame datapath: length latch, byte assembly, word address, checksum
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_len      <= 16'd0;
            r_byte_idx <= 2'd0;
            r_waddr    <= '0;
            r_word     <= 24'd0;
            r_csum     <= 8'd0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data_i == MAGIC) begin
                        r_csum     <= 8'd0;
                        r_byte_idx <= 2'd0;
                        r_waddr    <= '0;
                    end
                end
                S_LEN0: begin
                    r_len[7:0] <= rx_data_i;
                end
                S_LEN1: begin
                    r_len[15:8] <= rx_data_i;
                    r_byte_idx  <= 2'd0;
                    r_waddr     <= '0;
                end
                S_DATA: begin
                    r_csum     <= r_csum ^ rx_data_i;
                    r_byte_idx <= r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0:    r_word[7:0]   <= rx_data_i;
                        2'd1:    r_word[15:8]  <= rx_data_i;
                        2'd2:    r_word[23:16] <= rx_data_i;
                        default: r_waddr       <= r_waddr + 1'b1;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_boot_loader
//  Description : Self-checking bench for rom_boot_loader (ADDR_W=4,
//                TIMEOUT=8). Frames are built from the frame rules as byte
//                queues with the writes and outcome they must produce.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_boot_loader;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned WORDS   = 1 << ADDR_W;
    localparam logic [7:0]  MAGIC   = 8'hA5;

    logic              clk;
    logic              rest;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              rx_ready_o;
    logic              rom_we_o;
    logic [ADDR_W-1:0] rom_waddr_o;
    logic [31:0]       rom_wdata_o;
    logic              cpu_rest_o;
    logic              boot_done_o;
    logic              boot_err_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_we     = 0;

    // Expected frame: bytes, and for each byte whether it completes a word
    logic [7:0]  byte_q[$];
    bit          we_q[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] fixed_w[$];
    bit          exp_ok;
    int          exp_words;

    rom_boot_loader #(
        .ADDR_W  (ADDR_W),
        .MAGIC   (MAGIC),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rest        (rest),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .rom_we_o    (rom_we_o),
        .rom_waddr_o (rom_waddr_o),
        .rom_wdata_o (rom_wdata_o),
        .cpu_rest_o  (cpu_rest_o),
        .boot_done_o (boot_done_o),
        .boot_err_o  (boot_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every write-strobe cycle seen on the ROM port
    always @(negedge clk) begin
        if (rom_we_o) n_we <= n_we + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit we, input int wa, input logic [31:0] wd);
        byte_q.push_back(b);
        we_q.push_back(we);
        wa_q.push_back(wa);
        wd_q.push_back(wd);
    endtask

    task automatic clear_frame();
        byte_q.delete(); we_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    task automatic add_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == MAGIC) b = 8'h00;
            push_byte(b, 1'b0, 0, 32'd0);
        end
    endtask

    // Frame body: magic, length, payload words, XOR checksum (optionally corrupted)
    task automatic add_body(input int len, input bit bad_cs);
        logic [7:0]  cs;
        logic [31:0] w;
        push_byte(MAGIC, 1'b0, 0, 32'd0);
        push_byte(8'(len), 1'b0, 0, 32'd0);
        push_byte(8'(len >> 8), 1'b0, 0, 32'd0);
        if (len > int'(WORDS)) begin
            exp_ok    = 1'b0;
            exp_words = 0;
            return;
        end
        cs = 8'h00;
        for (int k = 0; k < len; k++) begin
            w = (fixed_w.size() > k) ? fixed_w[k] : $urandom;
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ w[8*j +: 8];
                push_byte(w[8*j +: 8], j == 3, k % int'(WORDS), w);
            end
        end
        push_byte(cs ^ {7'd0, bad_cs}, 1'b0, 0, 32'd0);
        exp_ok    = !bad_cs;
        exp_words = len;
    endtask

    // Present one byte after an idle gap; returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) @(negedge clk);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        t = 0;
        while (!rx_ready_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready_o) chk_eq("ready_wait", {31'd0, rx_ready_o}, 32'd1);
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    // Play the first 'limit' bytes of the frame (all if limit < 0)
    task automatic play(input int gap_max, input int limit);
        int base;
        int n;
        base = n_we;
        n = (limit < 0) ? byte_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            send_byte(byte_q[i], $urandom_range(0, gap_max));
            chk_eq("we_strobe", {31'd0, rom_we_o}, {31'd0, we_q[i]});
            if (we_q[i]) begin
                chk_eq("waddr", 32'(rom_waddr_o), 32'(wa_q[i]));
                chk_eq("wdata", rom_wdata_o, wd_q[i]);
            end
        end
        if (limit < 0) begin
            chk_eq("boot_done", {31'd0, boot_done_o}, {31'd0, exp_ok});
            chk_eq("cpu_rest",  {31'd0, cpu_rest_o},  {31'd0, exp_ok});
            chk_eq("boot_err",  {31'd0, boot_err_o},  {31'd0, !exp_ok});
            chk_eq("ready_end", {31'd0, rx_ready_o},  32'd0);
            chk_eq("we_count",  32'(n_we - base),     32'(exp_words));
        end
    endtask

    // Asynchronous reset mid-cycle, outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 rest = 1'b0;
        #1;
        chk_eq("rst_ready", {31'd0, rx_ready_o}, 32'd0);
        chk_eq("rst_we",    {31'd0, rom_we_o},   32'd0);
        chk_eq("rst_waddr", 32'(rom_waddr_o),    32'd0);
        chk_eq("rst_wdata", rom_wdata_o,         32'd0);
        chk_eq("rst_cpu",   {31'd0, cpu_rest_o}, 32'd0);
        chk_eq("rst_done",  {31'd0, boot_done_o}, 32'd0);
        chk_eq("rst_err",   {31'd0, boot_err_o}, 32'd0);
        @(negedge clk);
        rest = 1'b1;
        @(negedge clk);
        chk_eq("ready_after_rst", {31'd0, rx_ready_o}, 32'd1);
    endtask

    initial begin
        int len;
        rest       = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (2) @(negedge clk);
        chk_eq("init_ready", {31'd0, rx_ready_o}, 32'd0);
        chk_eq("init_cpu",   {31'd0, cpu_rest_o}, 32'd0);
        rest = 1'b1;
        @(negedge clk);
        chk_eq("ready_first", {31'd0, rx_ready_o}, 32'd1);

        // Normal load, back-to-back
        fixed_w = '{32'h0000_0013, 32'h0010_0093};
        clear_frame(); add_body(2, 1'b0); play(0, -1);

        // Bad checksum on the same image
        do_reset();
        clear_frame(); add_body(2, 1'b1); play(0, -1);
        fixed_w.delete();

        // Zero length after garbage 00 FF
        do_reset();
        clear_frame();
        push_byte(8'h00, 1'b0, 0, 32'd0);
        push_byte(8'hFF, 1'b0, 0, 32'd0);
        add_body(0, 1'b0); play(0, -1);

        // Oversize length, then a full-ROM image
        do_reset();
        clear_frame(); add_body(WORDS + 1, 1'b0); play(0, -1);
        do_reset();
        clear_frame(); add_body(WORDS, 1'b0); play(3, -1);

        // Timeout: stop after 5 payload bytes
        do_reset();
        clear_frame(); add_body(3, 1'b0); play(0, 8);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk_eq("tmo_early_err", {31'd0, boot_err_o}, 32'd0);
        @(negedge clk);
        chk_eq("tmo_err",   {31'd0, boot_err_o}, 32'd1);
        chk_eq("tmo_cpu",   {31'd0, cpu_rest_o}, 32'd0);
        chk_eq("tmo_ready", {31'd0, rx_ready_o}, 32'd0);

        // Maximum legal gap between every byte
        do_reset();
        clear_frame(); add_body(2, 1'b0);
        for (int i = 0; i < byte_q.size(); i++) begin
            send_byte(byte_q[i], TIMEOUT - 1);
        end
        chk_eq("gap7_done", {31'd0, boot_done_o}, 32'd1);
        chk_eq("gap7_err",  {31'd0, boot_err_o},  32'd0);

        // Reset after the first word, then a complete load with gaps
        do_reset();
        clear_frame(); add_body(3, 1'b0); play(2, 7);
        do_reset();
        clear_frame(); add_body(3, 1'b0); play(TIMEOUT - 1, -1);

        // Randomized frames
        for (int f = 0; f < 15; f++) begin
            do_reset();
            clear_frame();
            add_garbage($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) len = $urandom_range(WORDS + 1, 1000);
            else                           len = $urandom_range(0, WORDS);
            add_body(len, $urandom_range(0, 3) == 0);
            play(($urandom_range(0, 1) == 1) ? TIMEOUT - 1 : 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
